// File: rtl/avalon_input_pio_irq.sv
// Avalon-MM input PIO: pin synchroniser, optional per-bit debounce (AVALON_PIO_DEBOUNCE_EN), edge capture and maskable irq.
// Latency: readdata 1 cycle after address; pin to RAW SYNC_STAGES+1 cycles; stable change to irq 2 cycles.
// Backpressure: none; the slave accepts every access with fixed latency and never stalls the bus.
module avalon_input_pio_irq #(
  parameter int WIDTH           = 10,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int EDGE_MODE       = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             chipselect,
  input  logic [1:0]       address,
  input  logic             write,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam int                INIT_W    = $clog2(SYNC_STAGES + 1) + 1;
  localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'(SYNC_STAGES);

  typedef enum logic {
    INIT,
    RUN
  } state_t;

  state_t             state_q;
  state_t             state_d;
  logic               init_done;
  logic [INIT_W-1:0]  init_cnt_q;

  logic [WIDTH-1:0]   sync_q [SYNC_STAGES];
  logic [WIDTH-1:0]   sync;
  logic [WIDTH-1:0]   stable_q;
  logic [WIDTH-1:0]   stable_prev_q;
  logic [WIDTH-1:0]   edge_hit;
  logic [WIDTH-1:0]   capture_q;
  logic [WIDTH-1:0]   capture_clr;
  logic [WIDTH-1:0]   mask_q;
  logic               mask_we;
  logic [31:0]        rd_mux;

  // Bits of writedata above WIDTH carry no meaning for any register.
  logic unused_wdata;
  assign unused_wdata = ^writedata;

  assign sync = sync_q[SYNC_STAGES-1];

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= INIT;
    else          state_q <= state_d;
  end

  // Next state: INIT lasts SYNC_STAGES+1 cycles so the synchroniser holds real pin levels on exit.
  always_comb begin
    state_d   = state_q;
    init_done = 1'b0;
    case (state_q)
      INIT: begin
        if (init_cnt_q == INIT_LAST) begin
          init_done = 1'b1;
          state_d   = RUN;
        end
      end
      RUN:     state_d = RUN;
      default: state_d = INIT;
    endcase
  end

  // Cycle counter for the INIT period.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                        init_cnt_q <= '0;
    else if (state_q == INIT && !init_done) init_cnt_q <= init_cnt_q + INIT_W'(1);
  end

  // Multi-flop synchroniser for the asynchronous pins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= in_port;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

`ifdef AVALON_PIO_DEBOUNCE_EN
  localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q [WIDTH];

  // Per-bit debounce: accept a new level only after it has differed for DEBOUNCE_CYCLES cycles in a row.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stable_q <= '0;
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
    end else if (state_q == INIT) begin
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
      if (init_done) stable_q <= sync;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (sync[i] == stable_q[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] == CNT_LAST) begin
          stable_q[i] <= sync[i];
          cnt_q[i]    <= '0;
        end else begin
          cnt_q[i] <= cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end
`else
  // Without debounce the stable value is simply the synchronised value one cycle later.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                        stable_q <= '0;
    else if (state_q == RUN || init_done) stable_q <= sync;
  end
`endif

  // Previous stable value; loaded together with stable on INIT exit so reset-time levels give no edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)             stable_prev_q <= '0;
    else if (init_done)       stable_prev_q <= sync;
    else if (state_q == RUN)  stable_prev_q <= stable_q;
  end

  // Edge selection on the stable value.
  always_comb begin
    edge_hit = '0;
    if (state_q == RUN) begin
      case (EDGE_MODE)
        0:       edge_hit = stable_q & ~stable_prev_q;
        1:       edge_hit = ~stable_q & stable_prev_q;
        default: edge_hit = stable_q ^ stable_prev_q;
      endcase
    end
  end

  assign capture_clr = (chipselect && write && address == 2'd3) ? writedata[WIDTH-1:0] : '0;
  assign mask_we     = chipselect && write && address == 2'd2;

  // Sticky capture; a new edge beats a simultaneous clear on the same bit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) capture_q <= '0;
    else          capture_q <= (capture_q & ~capture_clr) | edge_hit;
  end

  // Interrupt mask register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    mask_q <= '0;
    else if (mask_we) mask_q <= writedata[WIDTH-1:0];
  end

  // Registered level interrupt.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) irq <= 1'b0;
    else          irq <= |(capture_q & mask_q);
  end

  // Read mux, zero-extended to the bus width.
  always_comb begin
    rd_mux = '0;
    case (address)
      2'd0:    rd_mux[WIDTH-1:0] = stable_q;
      2'd1:    rd_mux[WIDTH-1:0] = sync;
      2'd2:    rd_mux[WIDTH-1:0] = mask_q;
      default: rd_mux[WIDTH-1:0] = capture_q;
    endcase
  end

  // Read data register: updated every cycle, reads have no side effects.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) readdata <= '0;
    else          readdata <= rd_mux;
  end

endmodule

// File: tb/tb_avalon_input_pio_irq.sv
// Bench for avalon_input_pio_irq: rising-edge and falling-edge instances share all inputs.
// Inputs driven on the falling edge, outputs sampled on the falling edge.
// Expected values are hand-computed per vector and per sequence.
module tb_avalon_input_pio_irq;

  localparam int DEB = 4;
`ifdef AVALON_PIO_DEBOUNCE_EN
  localparam int   LAT        = 2 + DEB;
  localparam logic GLITCH_CAP = 1'b0;
`else
  localparam int   LAT        = 3;
  localparam logic GLITCH_CAP = 1'b1;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic        chipselect;
  logic [1:0]  address;
  logic        write;
  logic [31:0] writedata;
  logic [9:0]  in_port;
  logic [31:0] readdata;
  logic        irq;
  logic [31:0] f_readdata;
  logic        f_irq;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  avalon_input_pio_irq #(
    .WIDTH(10), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(DEB), .EDGE_MODE(0)
  ) dut (
    .clk(clk), .reset_n(reset_n), .chipselect(chipselect), .address(address),
    .write(write), .writedata(writedata), .in_port(in_port),
    .readdata(readdata), .irq(irq)
  );

  avalon_input_pio_irq #(
    .WIDTH(10), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(DEB), .EDGE_MODE(1)
  ) dut_f (
    .clk(clk), .reset_n(reset_n), .chipselect(chipselect), .address(address),
    .write(write), .writedata(writedata), .in_port(in_port),
    .readdata(f_readdata), .irq(f_irq)
  );

  typedef struct {
    logic [1:0]  addr;
    logic        cs;
    logic        wr;
    logic [31:0] wd;
    logic [9:0]  pins;
    logic [31:0] rd;
    logic        irq;
    logic [31:0] frd;
    logic        firq;
  } vec_t;

  vec_t vt [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic wr_reg(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    chipselect = 1'b1;
    write      = 1'b1;
    writedata  = d;
    cyc();
    chipselect = 1'b0;
    write      = 1'b0;
    writedata  = '0;
  endtask

  task automatic settle(input logic [9:0] p);
    in_port = p;
    repeat (14) cyc();
  endtask

  initial begin
    //            addr  cs    wr    wd            pins    rd            irq   frd           firq
    vt[0]  = '{2'd3, 1'b0, 1'b0, 32'h0,        10'h3FF, 32'h000, 1'b0, 32'h000, 1'b0};
    vt[1]  = '{2'd2, 1'b1, 1'b1, 32'hFFFFFFFF, 10'h3FF, 32'h3FF, 1'b0, 32'h3FF, 1'b0};
    vt[2]  = '{2'd2, 1'b0, 1'b1, 32'h0,        10'h3FF, 32'h3FF, 1'b0, 32'h3FF, 1'b0};
    vt[3]  = '{2'd0, 1'b1, 1'b1, 32'h0,        10'h3FF, 32'h3FF, 1'b0, 32'h3FF, 1'b0};
    vt[4]  = '{2'd1, 1'b1, 1'b1, 32'h0,        10'h155, 32'h155, 1'b0, 32'h155, 1'b1};
    vt[5]  = '{2'd3, 1'b0, 1'b0, 32'h0,        10'h155, 32'h000, 1'b0, 32'h2AA, 1'b1};
    vt[6]  = '{2'd0, 1'b0, 1'b0, 32'h0,        10'h3FF, 32'h3FF, 1'b1, 32'h3FF, 1'b1};
    vt[7]  = '{2'd3, 1'b0, 1'b0, 32'h0,        10'h3FF, 32'h2AA, 1'b1, 32'h2AA, 1'b1};
    vt[8]  = '{2'd3, 1'b1, 1'b1, 32'h0AA,      10'h3FF, 32'h200, 1'b1, 32'h200, 1'b1};
    vt[9]  = '{2'd2, 1'b1, 1'b1, 32'h0FF,      10'h3FF, 32'h0FF, 1'b0, 32'h0FF, 1'b0};
    vt[10] = '{2'd3, 1'b1, 1'b1, 32'hFFFFFFFF, 10'h3FF, 32'h000, 1'b0, 32'h000, 1'b0};
    vt[11] = '{2'd2, 1'b1, 1'b1, 32'h0,        10'h3FF, 32'h000, 1'b0, 32'h000, 1'b0};

    reset_n    = 1'b0;
    chipselect = 1'b0;
    address    = 2'd0;
    write      = 1'b0;
    writedata  = '0;
    in_port    = 10'h3FF;
    cyc();
    chk("reset readdata", readdata, 32'h0);
    chk("reset irq", {31'b0, irq}, 32'h0);
    chk("reset f_readdata", f_readdata, 32'h0);
    chk("reset f_irq", {31'b0, f_irq}, 32'h0);

    // INIT length: DATA still 0 after 3 cycles, pin levels appear on the 4th.
    reset_n = 1'b1;
    repeat (3) cyc();
    chk("init data pending", readdata, 32'h0);
    cyc();
    chk("init data loaded", readdata, 32'h3FF);

    for (int i = 0; i < 12; i++) begin
      address    = vt[i].addr;
      in_port    = vt[i].pins;
      chipselect = vt[i].cs;
      write      = vt[i].wr;
      writedata  = vt[i].wd;
      cyc();
      chipselect = 1'b0;
      write      = 1'b0;
      writedata  = '0;
      repeat (13) cyc();
      chk($sformatf("vec%0d readdata", i), readdata, vt[i].rd);
      chk($sformatf("vec%0d irq", i), {31'b0, irq}, {31'b0, vt[i].irq});
      chk($sformatf("vec%0d f_readdata", i), f_readdata, vt[i].frd);
      chk($sformatf("vec%0d f_irq", i), {31'b0, f_irq}, {31'b0, vt[i].firq});
    end

    // Mask write and clear write latency to irq.
    settle(10'h3FE);
    settle(10'h3FF);
    wr_reg(2'd2, 32'h001);
    chk("mask write irq still low", {31'b0, irq}, 32'h0);
    chk("mask write f_irq still low", {31'b0, f_irq}, 32'h0);
    cyc();
    chk("mask write irq high", {31'b0, irq}, 32'h1);
    chk("mask write f_irq high", {31'b0, f_irq}, 32'h1);
    wr_reg(2'd3, 32'h001);
    chk("clear irq still high", {31'b0, irq}, 32'h1);
    cyc();
    chk("clear irq low", {31'b0, irq}, 32'h0);
    chk("clear f_irq low", {31'b0, f_irq}, 32'h0);
    chk("clear capture zero", readdata, 32'h0);

    // Clear write landing on the same edge that sets capture[0].
    settle(10'h3FE);
    address = 2'd3;
    in_port = 10'h3FF;
    repeat (LAT) cyc();
    chipselect = 1'b1;
    write      = 1'b1;
    writedata  = 32'h001;
    cyc();
    chipselect = 1'b0;
    write      = 1'b0;
    writedata  = '0;
    chk("collision irq latency", {31'b0, irq}, 32'h0);
    cyc();
    chk("collision irq", {31'b0, irq}, 32'h1);
    chk("collision capture", readdata, 32'h001);
    repeat (3) cyc();
    chk("collision irq held", {31'b0, irq}, 32'h1);
    wr_reg(2'd3, 32'hFFFFFFFF);

    // Exact RAW and DATA latency.
    address = 2'd1;
    in_port = 10'h3FB;
    repeat (2) cyc();
    chk("raw latency old", readdata, 32'h3FF);
    cyc();
    chk("raw latency new", readdata, 32'h3FB);
    repeat (12) cyc();
    address = 2'd0;
    in_port = 10'h3FF;
    repeat (LAT) cyc();
    chk("data latency old", readdata, 32'h3FB);
    cyc();
    chk("data latency new", readdata, 32'h3FF);

    // Three-cycle pulse on bit 0, then a long hold.
    wr_reg(2'd3, 32'hFFFFFFFF);
    settle(10'h3FE);
    wr_reg(2'd3, 32'hFFFFFFFF);
    address = 2'd1;
    in_port = 10'h3FF;
    repeat (3) cyc();
    in_port = 10'h3FE;
    cyc();
    chk("glitch raw visible", readdata, 32'h3FF);
    repeat (12) cyc();
    address = 2'd0;
    repeat (2) cyc();
    chk("glitch data", readdata, 32'h3FE);
    address = 2'd3;
    repeat (2) cyc();
    chk("glitch capture", readdata, {31'b0, GLITCH_CAP});
    chk("glitch irq", {31'b0, irq}, {31'b0, GLITCH_CAP});
    settle(10'h3FF);
    chk("hold capture", readdata, 32'h001);
    chk("hold irq", {31'b0, irq}, 32'h1);
    address = 2'd0;
    repeat (2) cyc();
    chk("hold data", readdata, 32'h3FF);

    // Bit 5 rise then fall: only the fall captures in the falling-edge instance.
    wr_reg(2'd3, 32'hFFFFFFFF);
    settle(10'h3DF);
    wr_reg(2'd3, 32'hFFFFFFFF);
    settle(10'h3FF);
    chk("bit5 rise capture", readdata, 32'h020);
    chk("bit5 rise f_capture", f_readdata, 32'h000);
    settle(10'h3DF);
    chk("bit5 fall capture", readdata, 32'h020);
    chk("bit5 fall f_capture", f_readdata, 32'h020);

    // Reset in the middle of a debounce window.
    wr_reg(2'd2, 32'h3FF);
    in_port = 10'h155;
    repeat (3) cyc();
    chk("pre-reset mask read", readdata, 32'h3FF);
    reset_n = 1'b0;
    #1;
    chk("async reset readdata", readdata, 32'h0);
    chk("async reset irq", {31'b0, irq}, 32'h0);
    chk("async reset f_readdata", f_readdata, 32'h0);
    chk("async reset f_irq", {31'b0, f_irq}, 32'h0);
    repeat (2) cyc();
    reset_n = 1'b1;
    repeat (3) cyc();
    chk("post-reset mask", readdata, 32'h0);
    address = 2'd3;
    repeat (14) cyc();
    chk("post-reset capture", readdata, 32'h0);
    chk("post-reset irq", {31'b0, irq}, 32'h0);
    chk("post-reset f_capture", f_readdata, 32'h0);
    chk("post-reset f_irq", {31'b0, f_irq}, 32'h0);
    address = 2'd1;
    in_port = 10'h0AA;
    repeat (2) cyc();
    chk("post-reset raw old", readdata, 32'h155);
    cyc();
    chk("post-reset raw new", readdata, 32'h0AA);
    repeat (12) cyc();
    address = 2'd0;
    in_port = 10'h0AB;
    repeat (LAT) cyc();
    chk("post-reset data old", readdata, 32'h0AA);
    cyc();
    chk("post-reset data new", readdata, 32'h0AB);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
